// File: rtl/vic_responder_pkg.sv
// rtl/vic_responder_pkg.sv - shared constants for the vectored-interrupt responder
package vic_responder_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [15:0] SPUR_VEC_DEFAULT = 16'o000000;
    localparam int          NREQ_MAX         = 8;

endpackage

// File: rtl/vic_responder_prio_enc_n.sv
// rtl/vic_responder_prio_enc_n.sv - lowest-index-first priority encoder
module prio_enc_n #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vic_responder.sv
// rtl/vic_responder.sv - fixed-priority vectored interrupt responder (virq/istb/ivec/iack)
module vic_responder
    import vic_responder_pkg::*;
#(
    parameter int          NREQ     = 4,
    parameter logic [15:0] SPUR_VEC = SPUR_VEC_DEFAULT,
    parameter int          HOLDOFF  = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               vm_init,
    input  logic [NREQ-1:0]    irq_req,
    input  logic [NREQ-1:0]    irq_en,
    input  logic [16*NREQ-1:0] irq_vec,
    output logic [NREQ-1:0]    irq_ack,
    output logic               virq,
    input  logic               istb,
    output logic [15:0]        ivec,
    output logic               iack
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [NREQ-1:0] pend;
    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic [15:0]     sel_vec;
    logic [NREQ-1:0] ack_next;

    assign pend = irq_req & irq_en;

    prio_enc_n #(.N(NREQ), .IW(IW)) u_prio (
        .req   (pend),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        sel_vec = SPUR_VEC;
        for (int i = 0; i < NREQ; i++) begin
            if (win_valid && (win_idx == IW'(i))) begin
                sel_vec = irq_vec[16*i +: 16];
            end
        end
    end

    assign ack_next = win_valid ? (NREQ'(1) << win_idx) : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            virq    <= 1'b0;
            iack    <= 1'b0;
            ivec    <= '0;
            irq_ack <= '0;
        end else if (vm_init) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            virq    <= 1'b0;
            iack    <= 1'b0;
            ivec    <= '0;
            irq_ack <= '0;
        end else begin
            irq_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (istb) begin
                        ivec    <= sel_vec;
                        iack    <= 1'b1;
                        virq    <= 1'b0;
                        irq_ack <= ack_next;
                        state   <= ST_ACK;
                    end else begin
                        virq <= |pend;
                    end
                end
                ST_ACK: begin
                    // ivec/iack stay frozen until the CPU releases the strobe.
                    if (!istb) begin
                        iack  <= 1'b0;
                        ivec  <= '0;
                        cnt   <= 4'(HOLDOFF);
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vic_responder.sv
// tb/tb_vic_responder.sv - scoreboard bench for vic_responder
module tb_vic_responder;

    localparam int NREQ = 4;
    localparam logic [15:0] SPUR = 16'o000000;
    localparam logic [15:0] V0 = 16'o000060;
    localparam logic [15:0] V1 = 16'o000064;
    localparam logic [15:0] V2 = 16'o000070;
    localparam logic [15:0] V3 = 16'o000074;

    typedef struct {
        logic [15:0]     vec;
        logic [NREQ-1:0] ack;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               vm_init;
    logic [NREQ-1:0]    irq_req;
    logic [NREQ-1:0]    irq_en;
    logic [16*NREQ-1:0] irq_vec;
    logic [NREQ-1:0]    irq_ack;
    logic               virq;
    logic               istb;
    logic [15:0]        ivec;
    logic               iack;

    int checks   = 0;
    int failures = 0;
    int hs_seen  = 0;
    int hs_exp   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vic_responder #(.NREQ(NREQ), .SPUR_VEC(SPUR), .HOLDOFF(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .vm_init  (vm_init),
        .irq_req  (irq_req),
        .irq_en   (irq_en),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .virq     (virq),
        .istb     (istb),
        .ivec     (ivec),
        .iack     (iack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each rising iack, then watches stability and the one-cycle ack pulse.
    logic        iack_prev = 1'b0;
    logic        first_cyc = 1'b0;
    logic [15:0] held_vec  = '0;
    always @(negedge clk) begin
        if (iack && !iack_prev) begin
            hs_seen++;
            if (sb.size() == 0) begin
                check("unexpected_iack", 32'(ivec), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ivec", 32'(ivec), 32'(e.vec));
                check("irq_ack", 32'(irq_ack), 32'(e.ack));
            end
            held_vec  = ivec;
            first_cyc = 1'b1;
        end else if (iack) begin
            check("ivec_stable", 32'(ivec), 32'(held_vec));
            if (first_cyc) check("irq_ack_pulse_len", 32'(irq_ack), 32'(0));
            first_cyc = 1'b0;
        end
        iack_prev = iack;
    end

    task automatic push(input logic [15:0] v, input logic [NREQ-1:0] a);
        exp_t e;
        e.vec = v;
        e.ack = a;
        sb.push_back(e);
        hs_exp++;
    endtask

    // Full handshake: strobe held 3 cycles, device clears its served request, ends on the istb-low edge.
    task automatic hs(input logic [15:0] v, input logic [NREQ-1:0] a);
        push(v, a);
        istb = 1'b1;
        tick(1);
        irq_req = irq_req & ~a;
        tick(2);
        istb = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; vm_init = 1'b0; istb = 1'b0;
        irq_req = '0; irq_en = 4'b1111;
        irq_vec = {V3, V2, V1, V0};
        tick(2);
        check("rst_virq", 32'(virq), 0);
        check("rst_iack", 32'(iack), 0);
        check("rst_ivec", 32'(ivec), 0);
        check("rst_irq_ack", 32'(irq_ack), 0);

        // Single request, 1-cycle virq latency
        rst = 1'b0; irq_req = 4'b0001;
        #1 check("virq_before_edge", 32'(virq), 0);
        tick(1);
        check("virq_latency", 32'(virq), 1);
        hs(V0, 4'b0001);
        tick(3);

        // Two simultaneous, priority and holdoff
        irq_req = 4'b1010;
        tick(1);
        check("virq_1010", 32'(virq), 1);
        hs(V1, 4'b0010);
        tick(2);
        check("virq_holdoff", 32'(virq), 0);
        tick(1);
        check("virq_after_holdoff", 32'(virq), 1);
        hs(V3, 4'b1000);
        tick(3);

        // Enable mask
        irq_en = 4'b1011; irq_req = 4'b0100;
        tick(2);
        check("virq_masked", 32'(virq), 0);
        irq_en = 4'b1111;
        tick(1);
        check("virq_unmasked", 32'(virq), 1);
        hs(V2, 4'b0100);
        tick(3);

        // Withdrawn request: spurious, then next pending wins
        irq_req = 4'b0001;
        tick(1);
        check("virq_before_withdraw", 32'(virq), 1);
        irq_req = 4'b0000;
        hs(SPUR, 4'b0000);
        tick(3);
        irq_req = 4'b0011;
        tick(1);
        irq_req = 4'b0010;
        hs(V1, 4'b0010);
        tick(3);

        // Higher priority arrives during ACK; vector table changes too
        irq_req = 4'b0100;
        tick(1);
        push(V2, 4'b0100);
        istb = 1'b1;
        tick(1);
        irq_req = 4'b0001;
        irq_vec[47:32] = 16'o000777;
        tick(2);
        check("ivec_frozen", 32'(ivec), 32'(V2));
        irq_vec = {V3, V2, V1, V0};
        istb = 1'b0;
        tick(3);
        check("virq_release_gap", 32'(virq), 0);
        tick(1);
        check("virq_src0_next", 32'(virq), 1);
        hs(V0, 4'b0001);
        tick(3);

        // Async reset mid-ACK
        irq_req = 4'b0010;
        tick(1);
        istb = 1'b1;
        tick(1);
        check("pre_rst_iack", 32'(iack), 1);
        check("pre_rst_ivec", 32'(ivec), 32'(V1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_iack", 32'(iack), 0);
        check("async_rst_virq", 32'(virq), 0);
        check("async_rst_ivec", 32'(ivec), 0);
        check("async_rst_irq_ack", 32'(irq_ack), 0);
        tick(1);
        rst = 1'b0; istb = 1'b0; irq_req = '0;
        tick(2);

        // vm_init during RELEASE
        irq_req = 4'b0100;
        tick(1);
        hs(V2, 4'b0100);
        irq_req = 4'b0001; vm_init = 1'b1;
        tick(1);
        check("init_virq", 32'(virq), 0);
        vm_init = 1'b0;
        tick(1);
        check("init_idle_virq", 32'(virq), 1);
        hs(V0, 4'b0001);
        tick(3);

        // istb raised during RELEASE is served at first IDLE edge
        irq_req = 4'b0011;
        tick(1);
        hs(V0, 4'b0001);
        push(V1, 4'b0010);
        istb = 1'b1;
        tick(2);
        check("istb_in_release", 32'(iack), 0);
        tick(1);
        check("istb_served_idle", 32'(iack), 1);
        irq_req = '0;
        tick(1);
        istb = 1'b0;
        tick(4);

        check("sb_empty", 32'(sb.size()), 0);
        check("hs_count", 32'(hs_seen), 32'(hs_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
